// File: rtl/alu_vector_checker.sv
// alu_vector_checker: built-in self-check around a 4-bit signed ALU.
// It streams packed vectors into the ALU operands and scores alu_out against each vector's expected field.
module alu_vector_checker #(
  parameter int NUM_VEC    = 256,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [13:0]      vec_data,
  output logic             vec_ready,
  output logic [3:0]       alu_i0,
  output logic [3:0]       alu_i1,
  output logic [1:0]       alu_c,
  input  logic [3:0]       alu_out,
  output logic             res_valid,
  output logic             res_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [7:0]       first_fail_idx,
  output logic             first_fail_valid,
  output logic             busy,
  output logic             done
);

  localparam int SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {IDLE, FETCH, SETTLE, CHECK, DONE} state_t;

  state_t           state;
  logic [3:0]       exp_reg;
  logic [7:0]       idx;
  logic [SET_W-1:0] settle_cnt;
  logic             match;

  assign vec_ready = (state == FETCH);

  // Case equality so an X/Z result from the ALU can never be scored as a pass.
  assign match = (alu_out === exp_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      alu_i0           <= '0;
      alu_i1           <= '0;
      alu_c            <= '0;
      exp_reg          <= '0;
      idx              <= '0;
      settle_cnt       <= '0;
      res_valid        <= 1'b0;
      res_pass         <= 1'b0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
            idx              <= '0;
            done             <= 1'b0;
            busy             <= 1'b1;
            state            <= FETCH;
          end
        end
        FETCH: begin
          if (vec_valid) begin
            alu_i0     <= vec_data[13:10];
            alu_i1     <= vec_data[9:6];
            alu_c      <= vec_data[5:4];
            exp_reg    <= vec_data[3:0];
            settle_cnt <= SET_W'(SETTLE_CYC);
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt - SET_W'(1);
          if (settle_cnt == SET_W'(1)) begin
            state <= CHECK;
          end
        end
        CHECK: begin
          res_valid <= 1'b1;
          res_pass  <= match;
          if (match) begin
            pass_cnt <= pass_cnt + CNT_W'(1);
          end else begin
            fail_cnt <= fail_cnt + CNT_W'(1);
            if (!first_fail_valid) begin
              first_fail_idx   <= idx;
              first_fail_valid <= 1'b1;
            end
          end
          // The last vector closes the run; a start seen here is deliberately dropped.
          if (idx == 8'(NUM_VEC - 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            idx   <= idx + 8'd1;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_vector_checker.sv
// Bench for alu_vector_checker: behavioural ALU, vector table, and result scoreboard.
module tb_alu_vector_checker;

  localparam int NUM_VEC    = 256;
  localparam int SETTLE_CYC = 1;
  localparam int CNT_W      = 9;

  typedef struct packed {
    logic [13:0] data;
    logic        exp_pass;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             vec_valid = 1'b0;
  logic [13:0]      vec_data = '0;
  logic             vec_ready;
  logic [3:0]       alu_i0;
  logic [3:0]       alu_i1;
  logic [1:0]       alu_c;
  logic [3:0]       alu_out;
  logic             res_valid;
  logic             res_pass;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;
  logic [7:0]       first_fail_idx;
  logic             first_fail_valid;
  logic             busy;
  logic             done;

  vec_t vec_tab [NUM_VEC];
  logic exp_q [$];
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   res_count = 0;

  alu_vector_checker #(
    .NUM_VEC   (NUM_VEC),
    .SETTLE_CYC(SETTLE_CYC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .vec_valid       (vec_valid),
    .vec_data        (vec_data),
    .vec_ready       (vec_ready),
    .alu_i0          (alu_i0),
    .alu_i1          (alu_i1),
    .alu_c           (alu_c),
    .alu_out         (alu_out),
    .res_valid       (res_valid),
    .res_pass        (res_pass),
    .pass_cnt        (pass_cnt),
    .fail_cnt        (fail_cnt),
    .first_fail_idx  (first_fail_idx),
    .first_fail_valid(first_fail_valid),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  // Stand-in 4-bit ALU: add, subtract, and, or (wraps like the real signed ALU).
  function automatic logic [3:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] c);
    case (c)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return a | b;
    endcase
  endfunction

  assign alu_out = alu_fn(alu_i0, alu_i1, alu_c);

  function automatic vec_t build_vec(input int i);
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] c;
    logic [7:0] iv;
    vec_t v;
    iv = 8'(i);
    a  = iv[3:0];
    b  = iv[7:4];
    c  = iv[1:0] ^ iv[5:4];
    if (i == 0) begin
      a = 4'b0011;
      b = 4'b0010;
      c = 2'b00;
    end
    v.data     = {a, b, c, alu_fn(a, b, c)};
    v.exp_pass = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected res_valid", 32'd1, 32'd0);
      end else begin
        checkOutput($sformatf("res_pass[%0d]", res_count), 32'(res_pass), 32'(exp_q.pop_front()));
      end
      res_count++;
    end
  end

  // Drive one vector from a negedge; returns on the negedge after it was accepted.
  task automatic send_vec(input logic [13:0] data, input logic exp_pass);
    int guard = 0;
    vec_valid = 1'b1;
    vec_data  = data;
    while (!vec_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!vec_ready) begin
      checkOutput("vec_ready timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(exp_pass);
    end
    @(negedge clk);
  endtask

  task automatic latencySeq(input logic [13:0] data, input logic exp_pass);
    vec_valid = 1'b1;
    vec_data  = data;
    checkOutput("lat vec_ready before H", 32'(vec_ready), 32'd1);
    exp_q.push_back(exp_pass);
    @(posedge clk);
    #1;
    checkOutput("lat alu_i0", 32'(alu_i0), 32'h3);
    checkOutput("lat alu_i1", 32'(alu_i1), 32'h2);
    checkOutput("lat alu_c", 32'(alu_c), 32'h0);
    checkOutput("lat vec_ready after H", 32'(vec_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat res_valid H+1", 32'(res_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat res_valid H+2", 32'(res_valid), 32'd1);
    checkOutput("lat vec_ready H+2", 32'(vec_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int bad0, input int bad1, input int bp_at,
                               input int start_at, input int rst_at, input bit lat);
    logic [13:0] d;
    logic        ok;
    int          guard;
    res_count = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NUM_VEC; i++) begin
      d  = vec_tab[i].data;
      ok = vec_tab[i].exp_pass;
      if (i == bad0 || i == bad1) begin
        d[3:0] = ~d[3:0];
        ok     = 1'b0;
      end
      if (i == rst_at) begin
        #3 rst = 1'b1;
        #1;
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst done", 32'(done), 32'd0);
        checkOutput("rst pass_cnt", 32'(pass_cnt), 32'd0);
        checkOutput("rst vec_ready", 32'(vec_ready), 32'd0);
        checkOutput("rst alu_i0", 32'(alu_i0), 32'd0);
        checkOutput("rst alu_c", 32'(alu_c), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        return;
      end
      if (i == bp_at) begin
        vec_valid = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("backpressure vec_ready", 32'(vec_ready), 32'd1);
        checkOutput("backpressure busy", 32'(busy), 32'd1);
      end
      if (i == 0 && lat) begin
        latencySeq(d, ok);
      end else begin
        if (i == start_at) start = 1'b1;
        send_vec(d, ok);
        start = 1'b0;
      end
    end
    // Pulse start during the final CHECK cycle; it must not restart the run.
    vec_valid = 1'b0;
    repeat (SETTLE_CYC) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!done && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    checkOutput("done after run", 32'(done), 32'd1);
    checkOutput("busy after run", 32'(busy), 32'd0);
  endtask

  task automatic checkTotals(input int exp_pass, input int exp_fail, input int exp_ffv, input int exp_ffi);
    checkOutput("pass_cnt", 32'(pass_cnt), 32'(exp_pass));
    checkOutput("fail_cnt", 32'(fail_cnt), 32'(exp_fail));
    checkOutput("first_fail_valid", 32'(first_fail_valid), 32'(exp_ffv));
    checkOutput("first_fail_idx", 32'(first_fail_idx), 32'(exp_ffi));
    checkOutput("res_valid pulses", 32'(res_count), 32'(NUM_VEC));
    checkOutput("scoreboard drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_VEC; i++) vec_tab[i] = build_vec(i);

    rst = 1'b1;
    #12;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset vec_ready", 32'(vec_ready), 32'd0);
    checkOutput("reset alu_i0", 32'(alu_i0), 32'd0);
    checkOutput("reset res_valid", 32'(res_valid), 32'd0);
    checkOutput("reset pass_cnt", 32'(pass_cnt), 32'd0);
    checkOutput("reset first_fail_valid", 32'(first_fail_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] golden run with latency, backpressure and start-while-busy");
    applyStimulus(-1, -1, 50, 40, -1, 1'b1);
    checkTotals(256, 0, 0, 0);

    $display("[TB] error injection at vectors 5 and 9");
    applyStimulus(5, 9, -1, -1, -1, 1'b0);
    checkTotals(254, 2, 1, 5);

    $display("[TB] reset at vector 100, then full rerun");
    applyStimulus(-1, -1, -1, -1, 100, 1'b0);
    @(negedge clk);
    applyStimulus(-1, -1, -1, -1, -1, 1'b0);
    checkTotals(256, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_vector_checker.md
Name: alu_vector_checker

Overview:
- Hardware self-check stage that sits around the 4-bit signed ALU (alu: I0, I1, C -> alu_out).
- Upstream, it accepts packed test-vector words over a valid/ready stream and drives the ALU operand and opcode inputs.
- Downstream, it samples alu_out after a settle window and compares it against the expected field of the vector.
- It keeps pass/fail counts and the index of the first failing vector, replacing the readmemb/display loop with synthesizable BIST logic.

Parameters:
- NUM_VEC, 256, number of vectors per run (1..256).
- SETTLE_CYC, 1, cycles operands are held before compare (>=1).
- CNT_W, 9, counter width; must satisfy 2^CNT_W > NUM_VEC.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a run; ignored while busy.
- vec_valid  in  1  upstream vector valid.
- vec_data  in  14  vector word: [13:10]=I0, [9:6]=I1, [5:4]=C, [3:0]=expected alu_out.
- vec_ready  out  1  checker accepts a vector this cycle.
- alu_i0  out  4  signed operand to ALU I0.
- alu_i1  out  4  signed operand to ALU I1.
- alu_c  out  2  opcode to ALU C.
- alu_out  in  4  ALU result (combinational from alu_i0/alu_i1/alu_c).
- res_valid  out  1  one-cycle pulse per checked vector.
- res_pass  out  1  result of the compare; qualified by res_valid (1 = match).
- pass_cnt  out  CNT_W  vectors matched this run.
- fail_cnt  out  CNT_W  vectors mismatched this run.
- first_fail_idx  out  8  index of the first mismatching vector.
- first_fail_valid  out  1  first_fail_idx holds a captured index.
- busy  out  1  run in progress.
- done  out  1  run complete; held high until the next start or reset.

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs and internal registers are 0. This includes alu_i0/alu_i1/alu_c, counters, idx, done and busy.
- FSM states: IDLE, FETCH, SETTLE, CHECK, DONE.
- IDLE / DONE, start=1:
  - clear pass_cnt, fail_cnt, first_fail_idx, first_fail_valid, idx and done;
  - busy<=1; go to FETCH.
- FETCH:
  - vec_ready=1 (combinational from state).
  - On vec_valid&vec_ready: register vec_data fields into alu_i0, alu_i1, alu_c and exp_reg; load settle counter with SETTLE_CYC; go to SETTLE.
  - With no vec_valid: stay in FETCH; outputs hold.
- SETTLE: decrement the settle counter each cycle; go to CHECK after SETTLE_CYC cycles.
- CHECK, one cycle:
  - match = (alu_out == exp_reg), a full 4-bit compare.
  - In simulation, any X/Z on alu_out counts as a mismatch.
  - At the edge leaving CHECK: res_valid<=1 for one cycle and res_pass<=match.
  - On a match, pass_cnt+1.
  - On a mismatch, fail_cnt+1; if first_fail_valid=0, also capture first_fail_idx<=idx and set first_fail_valid<=1.
  - If idx==NUM_VEC-1: go to DONE, done<=1, busy<=0. Otherwise idx+1 and go to FETCH.
- Timing and hold rules:
  - Operands are stable from the accepting edge until the next accepting edge.
  - vec_ready is never high outside FETCH.
  - Per-vector latency: handshake edge H -> res_valid high in the cycle after edge H+SETTLE_CYC+1.
  - Minimum throughput: one vector per SETTLE_CYC+2 cycles.
- start pulses during FETCH/SETTLE/CHECK are ignored. start in the same cycle as the final CHECK is also ignored; a new start is needed from DONE.
- Counters cannot overflow: pass_cnt+fail_cnt<=NUM_VEC. Invariant at DONE: pass_cnt+fail_cnt==NUM_VEC.
- Reset mid-run aborts immediately to IDLE with everything cleared. No partial result is retained.
- The checker performs no arithmetic on operands; signedness matters only to the ALU.

Test Plan:
- Golden run: 256 vectors with correct expected values, vec_valid always 1 -> 256 res_valid pulses, all with res_pass=1; pass_cnt=256, fail_cnt=0, first_fail_valid=0, done=1, busy=0.
- Error injection: vector 5 expected flipped (e.g. 0101 -> 1010), vector 9 also wrong -> fail_cnt=2, pass_cnt=254, first_fail_idx=5, first_fail_valid=1.
- Latency, SETTLE_CYC=1: I0=0011, I1=0010, C=00 accepted at edge H -> alu_i0=0011 after H; res_valid high in the cycle after edge H+2; next vec_ready high the same cycle.
- Backpressure: vec_valid held low for 7 cycles mid-run -> checker waits in FETCH with vec_ready=1; counts and final totals are unchanged vs the golden run.
- Start while busy: start pulsed at vector 40 -> ignored; the run completes with pass_cnt=256.
- Reset mid-run: rst pulsed asynchronously at vector 100 -> all outputs 0 immediately, FSM in IDLE. A subsequent start with the full stream -> pass_cnt=256, done=1.
